// File: rtl/mdu_if.sv
// mdu_if: operand, move-to and result bundle between the execute stage and the MDU.
// master drives operands/moves, slave (the MDU) returns busy and HI/LO.
interface mdu_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wd;
    logic [31:0] wpc;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, A, B, hi_we, lo_we, wd, wpc,
        input  busy, hi, lo
    );

    modport slave (
        input  start, op, A, B, hi_we, lo_we, wd, wpc,
        output busy, hi, lo
    );
endinterface

// File: rtl/mdu.sv
// mdu: multiply/divide unit with HI/LO registers and a busy countdown for stalls.
// Optional MDU_TRACE_EN prints every HI/LO update tagged with the issuing PC.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic   clk,
    input logic   reset,
    mdu_if.slave  bus
);
    localparam int NMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(NMAX + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, next_state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] load_n;
    logic [31:0]   pend_hi, pend_lo;
    logic [31:0]   hi_q, lo_q;
    logic [31:0]   res_hi, res_lo;
    logic          launch, finish, move;

    logic [63:0]   prod_s, prod_u;
    logic [31:0]   quo_s, rem_s, quo_u, rem_u;
    logic          div_zero, div_ovf;

    assign prod_s   = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
    assign prod_u   = {32'b0, bus.A} * {32'b0, bus.B};
    assign quo_s    = $signed(bus.A) / $signed(bus.B);
    assign rem_s    = $signed(bus.A) % $signed(bus.B);
    assign quo_u    = bus.A / bus.B;
    assign rem_u    = bus.A % bus.B;
    assign div_zero = (bus.B == 32'h0);
    assign div_ovf  = (bus.A == 32'h8000_0000) && (bus.B == 32'hFFFF_FFFF);

    // Result and latency for the op presented on the bus this cycle
    always_comb begin
        res_hi = '0;
        res_lo = '0;
        load_n = CW'(MULT_CYCLES);
        unique case (bus.op)
            2'd0: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            2'd1: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            2'd2: begin
                load_n = CW'(DIV_CYCLES);
                if (div_zero) begin
                    res_hi = bus.A;
                    res_lo = 32'hFFFF_FFFF;
                end else if (div_ovf) begin
                    res_hi = 32'h0;
                    res_lo = 32'h8000_0000;
                end else begin
                    res_hi = rem_s;
                    res_lo = quo_s;
                end
            end
            default: begin
                load_n = CW'(DIV_CYCLES);
                if (div_zero) begin
                    res_hi = bus.A;
                    res_lo = 32'hFFFF_FFFF;
                end else begin
                    res_hi = rem_u;
                    res_lo = quo_u;
                end
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state: leave IDLE on start, return when the countdown expires
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (bus.start)       next_state = RUN;
            default: if (cnt == CW'(1))   next_state = IDLE;
        endcase
    end

    // FSM outputs; start shadows a same-cycle move-to
    always_comb begin
        busy_o_default: begin end
        launch = (state == IDLE) && bus.start;
        finish = (state == RUN) && (cnt == CW'(1));
        move   = (state == IDLE) && !bus.start;
    end

    // Countdown, pending result and architectural HI/LO
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            if (launch) begin
                cnt     <= load_n;
                pend_hi <= res_hi;
                pend_lo <= res_lo;
            end else if (state == RUN) begin
                cnt <= cnt - CW'(1);
            end
            if (finish) begin
                hi_q <= pend_hi;
                lo_q <= pend_lo;
            end else if (move) begin
                if (bus.hi_we) hi_q <= bus.wd;
                if (bus.lo_we) lo_q <= bus.wd;
            end
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

`ifdef MDU_TRACE_EN
    logic [31:0] pc_q;

    // PC of the op in flight, for tagging its result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      pc_q <= '0;
        else if (launch) pc_q <= bus.wpc;
    end

    // Trace every HI/LO update
    always @(posedge clk) begin
        if (reset) begin
            if (finish) begin
                $display("@%08h: HI <= %08h", pc_q, pend_hi);
                $display("@%08h: LO <= %08h", pc_q, pend_lo);
            end else if (move) begin
                if (bus.hi_we) $display("@%08h: HI <= %08h", bus.wpc, bus.wd);
                if (bus.lo_we) $display("@%08h: LO <= %08h", bus.wpc, bus.wd);
            end
        end
    end
`else
    logic unused_wpc;
    assign unused_wpc = ^bus.wpc;
`endif
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed checks of MDU latency, arithmetic, collisions and async reset.
// Expected values are hand-computed constants.
module tb_mdu;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mdu_if bus();

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        bus.wpc   = bus.wpc + 32'd4;
        step();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int n,
                             input logic [31:0] ehi, input logic [31:0] elo);
        for (int i = 1; i < n; i++) begin
            step();
            chk({tag, "_busy"}, {31'b0, bus.busy}, 32'd1);
        end
        step();
        chk({tag, "_idle"}, {31'b0, bus.busy}, 32'd0);
        chk({tag, "_hi"}, bus.hi, ehi);
        chk({tag, "_lo"}, bus.lo, elo);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 2'd0;
        bus.A     = '0;
        bus.B     = '0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wd    = '0;
        bus.wpc   = 32'h0040_0000;
        #1;
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_hi", bus.hi, 32'h0);
        chk("rst_lo", bus.lo, 32'h0);
        #11 reset = 1'b1;
        step();

        go(2'd0, 32'hFFFF_FFFD, 32'd7);
        chk("mult_k_busy", {31'b0, bus.busy}, 32'd1);
        chk("mult_k_oldhi", bus.hi, 32'h0);
        wait_done("mult", 5, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

        go(2'd1, 32'hFFFF_FFFF, 32'd2);
        wait_done("multu", 5, 32'h0000_0001, 32'hFFFF_FFFE);

        go(2'd2, 32'hFFFF_FFF9, 32'd2);
        wait_done("div", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        go(2'd3, 32'd7, 32'd0);
        wait_done("divu0", 10, 32'd7, 32'hFFFF_FFFF);

        go(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("divovf", 10, 32'h0, 32'h8000_0000);

        go(2'd0, 32'd3, 32'd5);
        go(2'd3, 32'd9, 32'd4);
        bus.hi_we = 1'b1;
        bus.wd    = 32'h0000_1234;
        step();
        bus.hi_we = 1'b0;
        chk("mthi_busy_hi", bus.hi, 32'h0);
        chk("coll_busy", {31'b0, bus.busy}, 32'd1);
        wait_done("coll", 3, 32'h0, 32'd15);

        bus.hi_we = 1'b1;
        bus.wd    = 32'hCAFE_BABE;
        step();
        bus.hi_we = 1'b0;
        chk("mthi_hi", bus.hi, 32'hCAFE_BABE);
        chk("mthi_lo", bus.lo, 32'd15);
        bus.lo_we = 1'b1;
        bus.wd    = 32'd1;
        step();
        bus.lo_we = 1'b0;
        chk("mtlo_lo", bus.lo, 32'd1);
        chk("mtlo_hi", bus.hi, 32'hCAFE_BABE);
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wd    = 32'h5A5A_5A5A;
        step();
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        chk("mvboth_hi", bus.hi, 32'h5A5A_5A5A);
        chk("mvboth_lo", bus.lo, 32'h5A5A_5A5A);

        bus.hi_we = 1'b1;
        bus.wd    = 32'hDEAD_BEEF;
        go(2'd0, 32'd2, 32'd3);
        bus.hi_we = 1'b0;
        chk("stmv_hi", bus.hi, 32'h5A5A_5A5A);
        wait_done("stmv", 5, 32'h0, 32'd6);

        go(2'd0, 32'hFFFF_FFFD, 32'd7);
        step();
        #2 reset = 1'b0;
        #1;
        chk("arst_busy", {31'b0, bus.busy}, 32'd0);
        chk("arst_hi", bus.hi, 32'h0);
        chk("arst_lo", bus.lo, 32'h0);
        step();
        step();
        #2 reset = 1'b1;
        for (int i = 0; i < 6; i++) step();
        chk("post_busy", {31'b0, bus.busy}, 32'd0);
        chk("post_hi", bus.hi, 32'h0);
        chk("post_lo", bus.lo, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mdu.md
Name: mdu

Overview:
Multiply/divide unit sitting beside the execute stage of the MIPS datapath.
- Consumes the two GRF read operands (rs, rt).
- Holds the architectural HI/LO registers, which feed the writeback mux (mfhi/mflo) back into the GRF.
- Models multi-cycle latency with a busy counter so the pipeline controller can stall dependent instructions.

Parameters:
MULT_CYCLES, 5, busy duration for MULT/MULTU (must be >= 1)
DIV_CYCLES, 10, busy duration for DIV/DIVU (must be >= 1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (asserted when 0)
start  input  1  launch operation selected by op; single-cycle pulse
op  input  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU
A  input  32  rs operand from GRF RD1
B  input  32  rt operand from GRF RD2
hi_we  input  1  mthi: write wd to HI
lo_we  input  1  mtlo: write wd to LO
wd  input  32  data for mthi/mtlo
wpc  input  32  PC of the instruction driving start/hi_we/lo_we (trace only)
busy  output  1  operation in flight
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset: reset=0 forces hi=0, lo=0, busy=0, internal counter=0 and pending results=0 immediately, without waiting for clk. This aborts any in-flight operation; its result is discarded.
- States:
  - IDLE (busy=0).
  - RUN (busy=1, counter counts down).
- IDLE, start=1 at edge k:
  - A and B are latched.
  - The result is computed from the latched values into pending_hi/pending_lo.
  - counter loads N = MULT_CYCLES or DIV_CYCLES.
  - The FSM enters RUN; busy is registered and reads 1 from edge k through edge k+N.
- RUN:
  - counter decrements each edge.
  - On the edge where counter==1, hi<=pending_hi, lo<=pending_lo, busy<=0, FSM returns to IDLE.
  - New hi/lo are therefore visible after edge k+N.
- Arithmetic:
  - MULT: signed 32x32 to 64-bit; hi=upper 32 bits, lo=lower 32 bits.
  - MULTU: as MULT, unsigned.
  - DIV: signed; lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - DIVU: as DIV, unsigned.
- Divide by zero (B==0, DIV or DIVU): hi=A, lo=32'hFFFFFFFF. Busy timing is unchanged.
- Signed overflow (DIV 32'h80000000 / -1): lo=32'h80000000, hi=0.
- start while busy=1: ignored. No restart, latched operands unchanged.
- hi_we/lo_we while busy=1: ignored. The controller must stall these; the unit does not queue them.
- IDLE, hi_we/lo_we:
  - hi_we=1 gives hi<=wd on the edge; lo_we=1 gives lo<=wd.
  - Both set: both registers are written with wd.
- IDLE, start together with hi_we/lo_we in the same cycle: start wins and the move-to write is dropped.
- hi/lo are directly readable every cycle.
  - Reading during RUN returns the old values.
  - The controller must stall mfhi/mflo when start|busy.

Optional Feature:
MDU_TRACE_EN
- Defined: on every edge that updates hi or lo, print "@<wpc>: HI <= <value>" and/or "@<wpc>: LO <= <value>" in 8-digit hex.
  - For operation results, wpc is the value latched at start.
  - For mthi/mtlo, wpc is the current input.
  - Requires a 32-bit PC latch.
- Undefined: no $display statements, no PC latch; wpc is unused.

Test Plan:
- Reset: reset=0 mid-RUN 2 cycles after a MULT start -> busy=0, hi=0, lo=0 immediately; after release, hi/lo stay 0.
- MULT A=-3 (32'hFFFFFFFD), B=7 -> busy=1 for exactly 5 edges, then hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
- MULTU A=32'hFFFFFFFF, B=2 -> hi=32'h00000001, lo=32'hFFFFFFFE.
- DIV A=-7, B=2 -> after 10 busy edges lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
  - DIVU A=7, B=0 -> hi=7, lo=32'hFFFFFFFF.
- Collisions:
  - start with op=DIVU, A=9, B=4 while busy from a MULT -> ignored; the MULT result lands and busy falls at the expected edge.
  - mthi wd=32'h1234 while busy -> hi unaffected.
- IDLE mthi wd=32'hCAFEBABE and mtlo wd=1 -> hi=32'hCAFEBABE, lo=1 next edge.
  - start+hi_we in the same cycle -> MULT result only, wd discarded.
